// File: rtl/reg32_mdr_if.sv
// Bus-side signal bundle for the Mini SRC memory data register.
// Signal names follow the datapath schematic so wiring reads one-to-one.
interface reg32_mdr_if;
  logic [31:0] BusMuxOut;
  logic [31:0] Mdatain;
  logic        read;
  logic        MDRin;
  logic [31:0] MDR_out;

  modport master (
    output BusMuxOut,
    output Mdatain,
    output read,
    output MDRin,
    input  MDR_out
  );

  modport slave (
    input  BusMuxOut,
    input  Mdatain,
    input  read,
    input  MDRin,
    output MDR_out
  );
endinterface

// File: rtl/reg32_mdr.sv
// 32-bit memory data register: loads either the internal bus or memory read data,
// selected by read and gated by MDRin, with a synchronous active-low clear.
module reg32_mdr (
  input  logic         clock,
  input  logic         clear,
  reg32_mdr_if.slave   bus
);

  logic [31:0] src_s;
  logic [31:0] data_d;
  logic [31:0] data_q;

  // Source select and load-enable next-state logic.
  always_comb begin
    src_s  = 32'h0000_0000;
    data_d = data_q;
    if (bus.read) begin
      src_s = bus.Mdatain;
    end else begin
      src_s = bus.BusMuxOut;
    end
    if (bus.MDRin) begin
      data_d = src_s;
    end else begin
      data_d = data_q;
    end
  end

  // Data register; clear takes priority over any load at the same edge.
  always_ff @(posedge clock) begin
    if (!clear) begin
      data_q <= 32'h0000_0000;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.MDR_out = data_q;

endmodule

// File: tb/tb_reg32_mdr.sv
// Directed-vector bench for reg32_mdr; expected values are hand-computed constants.
module tb_reg32_mdr;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_errors;

  reg32_mdr_if bus_if ();

  reg32_mdr dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear            = 1'b1;
    bus_if.MDRin     = 1'b0;
    bus_if.read      = 1'b0;
    bus_if.BusMuxOut = 32'h0000_0000;
    bus_if.Mdatain   = 32'h0000_0000;
    @(negedge clock);

    // Start-up clear
    clear = 1'b0; bus_if.MDRin = 1'b0;
    step();
    check_eq("startup_clear", bus_if.MDR_out, 32'h0000_0000);

    // Bus load
    clear = 1'b1; bus_if.read = 1'b0; bus_if.MDRin = 1'b1;
    bus_if.BusMuxOut = 32'h0000_0045; bus_if.Mdatain = 32'h0000_01A4;
    step();
    check_eq("bus_load", bus_if.MDR_out, 32'h0000_0045);

    // Clear wins over simultaneous load
    clear = 1'b0; bus_if.MDRin = 1'b1;
    step();
    check_eq("clear_priority", bus_if.MDR_out, 32'h0000_0000);

    // Hold with read asserted
    clear = 1'b1; bus_if.read = 1'b1; bus_if.MDRin = 1'b0;
    step();
    check_eq("hold_read1", bus_if.MDR_out, 32'h0000_0000);

    // Memory load
    bus_if.MDRin = 1'b1; bus_if.Mdatain = 32'h0000_01A4;
    step();
    check_eq("mem_load", bus_if.MDR_out, 32'h0000_01A4);

    // Mid-cycle changes with MDRin=1 only show after the next edge
    bus_if.Mdatain = 32'hFFFF_FFFF;
    #2;
    check_eq("midcycle_mem_nochange", bus_if.MDR_out, 32'h0000_01A4);
    step();
    check_eq("mem_load_all_ones", bus_if.MDR_out, 32'hFFFF_FFFF);

    bus_if.read = 1'b0; bus_if.BusMuxOut = 32'h1234_5678;
    #2;
    check_eq("midcycle_bus_nochange", bus_if.MDR_out, 32'hFFFF_FFFF);
    step();
    check_eq("bus_load_after_switch", bus_if.MDR_out, 32'h1234_5678);

    // Mid-cycle changes with MDRin=0 never reach the output
    bus_if.MDRin = 1'b0; bus_if.read = 1'b1; bus_if.Mdatain = 32'hFFFF_FFFF;
    bus_if.BusMuxOut = 32'h0BAD_F00D;
    #2;
    check_eq("hold_midcycle", bus_if.MDR_out, 32'h1234_5678);
    step();
    check_eq("hold_after_edge", bus_if.MDR_out, 32'h1234_5678);
    bus_if.read = 1'b0;
    step();
    check_eq("hold_read_toggle", bus_if.MDR_out, 32'h1234_5678);

    // Clear asserted between edges acts only at the next edge
    clear = 1'b0;
    #2;
    check_eq("clear_midcycle_noeffect", bus_if.MDR_out, 32'h1234_5678);
    step();
    check_eq("clear_at_edge", bus_if.MDR_out, 32'h0000_0000);

    // Release clear and load at the same edge
    clear = 1'b1; bus_if.MDRin = 1'b1; bus_if.read = 1'b0;
    bus_if.BusMuxOut = 32'hA5A5_5A5A;
    step();
    check_eq("release_and_load", bus_if.MDR_out, 32'hA5A5_5A5A);

    // Alternating bit pattern from memory path
    bus_if.read = 1'b1; bus_if.Mdatain = 32'h5A5A_A5A5;
    step();
    check_eq("mem_pattern", bus_if.MDR_out, 32'h5A5A_A5A5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
